// File: rtl/status_flag_register.sv
// NZCV producer: derives flags from the EXE-stage ALU result, stages them as a
// pending update for one cycle, then commits them to the architectural status.
module status_flag_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_en,
  input  logic [1:0]       op_kind,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       status,
  output logic [3:0]       fwd_status,
  output logic             pending_valid
);

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic [3:0] r_status;
  logic [3:0] r_pending;
  logic       r_pending_valid;

  logic [3:0] w_fwd;
  logic [3:0] w_flags;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_accept;

  // Newest flag view: the staged update overrides the committed value.
  assign w_fwd = r_pending_valid ? r_pending : r_status;

  assign w_n = alu_result[WIDTH-1];
  assign w_z = (alu_result == '0);

  always_comb begin
    w_c = w_fwd[1];
    w_v = w_fwd[0];
    case (op_kind)
      OP_ADD: begin
        w_c = alu_carry;
        w_v = (a_msb == b_msb) && (alu_result[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        w_c = alu_carry;
        w_v = (a_msb != b_msb) && (alu_result[WIDTH-1] != a_msb);
      end
      default: begin
        w_c = w_fwd[1];
        w_v = w_fwd[0];
      end
    endcase
  end

  assign w_flags  = {w_n, w_z, w_c, w_v};
  assign w_accept = s_en && !stall && !flush && (op_kind != OP_RSVD) && (op_kind == OP_LOGIC || op_kind == OP_ADD || op_kind == OP_SUB);

  // Flush kills the staged update and blocks acceptance; stall only blocks acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status        <= 4'b0000;
      r_pending       <= 4'b0000;
      r_pending_valid <= 1'b0;
    end else begin
      if (r_pending_valid && !flush) begin
        r_status <= r_pending;
      end
      if (w_accept) begin
        r_pending       <= w_flags;
        r_pending_valid <= 1'b1;
      end else begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  assign status        = r_status;
  assign fwd_status    = w_fwd;
  assign pending_valid = r_pending_valid;

endmodule

// File: tb/tb_status_flag_register.sv
// Self-checking bench for status_flag_register: directed scenarios plus random
// stimulus compared against an arithmetic reference model.
module tb_status_flag_register;

  logic        clk;
  logic        rst_n;
  logic        s_en;
  logic [1:0]  op_kind;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        a_msb;
  logic        b_msb;
  logic        stall;
  logic        flush;
  logic [3:0]  status;
  logic [3:0]  fwd_status;
  logic        pending_valid;

  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [3:0]  m_status;
  logic [3:0]  m_pend;
  logic        m_pv;

  int n_cmp;
  int n_bad;
  int n_txn;

  status_flag_register #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_en         (s_en),
    .op_kind      (op_kind),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .a_msb        (a_msb),
    .b_msb        (b_msb),
    .stall        (stall),
    .flush        (flush),
    .status       (status),
    .fwd_status   (fwd_status),
    .pending_valid(pending_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  // Flags from true arithmetic: carry is unsigned overflow / no-borrow,
  // overflow is the signed result not fitting in 32 bits.
  function automatic logic [3:0] ref_flags(input logic [1:0] k, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] res,
                                           input logic [3:0] fwd);
    longint d;
    logic n, z, c, v;
    n = res[31];
    z = (res == 32'd0);
    c = fwd[1];
    v = fwd[0];
    if (k == 2'b01) begin
      c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
      d = longint'($signed(a)) + longint'($signed(b));
      v = (d != longint'($signed(res)));
    end else if (k == 2'b10) begin
      c = (a >= b);
      d = longint'($signed(a)) - longint'($signed(b));
      v = (d != longint'($signed(res)));
    end
    return {n, z, c, v};
  endfunction

  task automatic set_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    op_kind = 2'b01; op_a = a; op_b = b;
    alu_result = s[31:0]; alu_carry = s[32];
    a_msb = a[31]; b_msb = b[31];
  endtask

  task automatic set_sub(input logic [31:0] a, input logic [31:0] b);
    op_kind = 2'b10; op_a = a; op_b = b;
    alu_result = a - b; alu_carry = (a >= b);
    a_msb = a[31]; b_msb = b[31];
  endtask

  task automatic set_other(input logic [1:0] k, input logic [31:0] res);
    op_kind = k; op_a = $urandom; op_b = $urandom;
    alu_result = res; alu_carry = 1'($urandom);
    a_msb = 1'($urandom); b_msb = 1'($urandom);
  endtask

  // One clock edge: model the edge from the spec rules, then check all outputs.
  task automatic step();
    logic [3:0] fwd, f;
    logic acc;
    fwd = m_pv ? m_pend : m_status;
    f   = ref_flags(op_kind, op_a, op_b, alu_result, fwd);
    acc = s_en && !stall && !flush && (op_kind != 2'b11);
    @(posedge clk);
    if (!rst_n) begin
      m_status = 4'b0; m_pend = 4'b0; m_pv = 1'b0;
    end else begin
      if (m_pv && !flush) m_status = m_pend;
      m_pv = acc;
      if (acc) m_pend = f;
    end
    @(negedge clk);
    n_txn++;
    $display("txn %0d rst_n=%0b s_en=%0b op=%0d stall=%0b flush=%0b res=%h -> status=%b fwd=%b pv=%0b",
             n_txn, rst_n, s_en, op_kind, stall, flush, alu_result, status, fwd_status, pending_valid);
    chk("status", 32'(status), 32'(m_status));
    chk("pending_valid", 32'(pending_valid), 32'(m_pv));
    chk("fwd_status", 32'(fwd_status), 32'(m_pv ? m_pend : m_status));
  endtask

  initial begin
    logic [31:0] specials [4];
    int r;
    n_cmp = 0; n_bad = 0; n_txn = 0;
    m_status = 4'b0; m_pend = 4'b0; m_pv = 1'b0;
    specials[0] = 32'h0000_0000; specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'hFFFF_FFFF;
    stall = 1'b0; flush = 1'b0; s_en = 1'b1; rst_n = 1'b0;
    set_add($urandom, $urandom);

    // Reset with s_en active
    step();
    set_sub($urandom, $urandom);
    step();
    chk("reset_status", 32'(status), 32'h0);
    chk("reset_fwd", 32'(fwd_status), 32'h0);
    chk("reset_pv", 32'(pending_valid), 32'h0);
    rst_n = 1'b1;

    // ADD overflow
    s_en = 1'b1; set_add(32'h7FFF_FFFF, 32'h1);
    step();
    chk("add_ovf_fwd", 32'(fwd_status), 32'b1001);
    chk("add_ovf_pv1", 32'(pending_valid), 32'h1);
    s_en = 1'b0;
    step();
    chk("add_ovf_status", 32'(status), 32'b1001);
    chk("add_ovf_pv0", 32'(pending_valid), 32'h0);

    // CMP equal then logic op keeping C/V from the pending CMP
    s_en = 1'b1; set_sub(32'd5, 32'd5);
    step();
    set_other(2'b00, 32'h8000_0000);
    step();
    chk("cmp_eq_status", 32'(status), 32'b0110);
    s_en = 1'b0;
    step();
    chk("logic_keep_cv", 32'(status), 32'b1010);

    // Back-to-back updates
    s_en = 1'b1; set_add(32'd1, 32'd2);
    step();
    set_sub(32'd5, 32'd5);
    step();
    chk("b2b_status0", 32'(status), 32'b0000);
    chk("b2b_pv", 32'(pending_valid), 32'h1);
    s_en = 1'b0;
    step();
    chk("b2b_status1", 32'(status), 32'b0110);

    // Flush kills pending CMP and a coincident accept
    s_en = 1'b1; set_add(32'h7FFF_FFFF, 32'h1);
    step();
    s_en = 1'b0;
    step();
    s_en = 1'b1; set_sub(32'd5, 32'd5);
    step();
    flush = 1'b1; set_add(32'd1, 32'd2);
    step();
    chk("flush_status", 32'(status), 32'b1001);
    chk("flush_pv", 32'(pending_valid), 32'h0);
    flush = 1'b0; s_en = 1'b0;
    step();
    chk("flush_after", 32'(status), 32'b1001);

    // Stall blocks accept but lets the pending update commit
    s_en = 1'b1; set_add(32'd1, 32'd2);
    step();
    stall = 1'b1; set_sub(32'd5, 32'd5);
    for (int i = 0; i < 3; i++) step();
    chk("stall_status", 32'(status), 32'b0000);
    chk("stall_pv", 32'(pending_valid), 32'h0);
    stall = 1'b0; s_en = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) >= 3);
      s_en  = ($urandom_range(0, 99) < 75);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 12);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        set_add(($urandom_range(0, 1) != 0) ? specials[$urandom_range(0, 3)] : $urandom,
                ($urandom_range(0, 1) != 0) ? specials[$urandom_range(0, 3)] : $urandom);
      end else if (r < 8) begin
        set_sub(($urandom_range(0, 1) != 0) ? specials[$urandom_range(0, 3)] : $urandom,
                ($urandom_range(0, 1) != 0) ? specials[$urandom_range(0, 3)] : $urandom);
      end else if (r == 8) begin
        set_other(2'b00, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      end else begin
        set_other(2'b11, $urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
